perceptron_trainer: RTL and testbench

- Parametrised training sequencer for a single `Perceptron` instance. Generalises the fixed two-input AND demo to N binary inputs and any truth table.
- Sweeps every input pattern for a bounded number of training epochs. Runs an evaluation pass after each epoch and stops early on full accuracy.
- Afterwards hands the perceptron inputs to live switches for inference. Sits between board I/O and `Perceptron`; the parent wires `values`, `expected`, `training` and `prediction`.

---
 rtl/perceptron_trainer_pkg.sv | 25 ++
 rtl/perceptron_trainer_if.sv | 27 ++
 rtl/perceptron_trainer_pattern_driver.sv | 77 +++++++
 rtl/perceptron_trainer.sv | 157 +++++++++++++++
 tb/tb_perceptron_trainer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/perceptron_trainer_pkg.sv
// Shared types for the perceptron training sequencer.
// Holds the fixed-point format, its constants and the FSM state enum.
package perceptron_trainer_pkg;

    localparam int SFP_W = 16;

    // Signed Q8.8 fixed point, as consumed by the perceptron.
    typedef logic signed [SFP_W-1:0] sfp;

    localparam sfp ONE  = 16'sh0100;
    localparam sfp HALF = 16'sh0080;

    typedef enum logic [1:0] {
        IDLE,
        TRAIN,
        EVAL,
        RUN
    } trainer_state_e;

    // Maps a binary input onto the perceptron's input scale.
    function automatic sfp sfp_from_bit(input logic b);
        return b ? ONE : '0;
    endfunction

endpackage

// File: rtl/perceptron_trainer_if.sv
// Link between the training sequencer and one perceptron instance.
// The trainer drives inputs and target; the perceptron returns its output.
interface perceptron_trainer_if #(
    parameter int N_INPUTS = 2
);
    import perceptron_trainer_pkg::*;

    sfp [N_INPUTS-1:0] values;
    sfp                expected;
    logic              training;
    sfp                prediction;

    modport master (
        output values,
        output expected,
        output training,
        input  prediction
    );

    modport slave (
        input  values,
        input  expected,
        input  training,
        output prediction
    );

endinterface

// File: rtl/perceptron_trainer_pattern_driver.sv
// Steps through input patterns, holding each for SETTLE_CYCLES.
// Produces perceptron values/target and strobes for the FSM.
module pattern_driver
    import perceptron_trainer_pkg::*;
#(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     active,
    input  logic                     run,
    input  logic [2**N_INPUTS-1:0]   tbl,
    input  logic [N_INPUTS-1:0]      sw_in,
    output sfp   [N_INPUTS-1:0]      values,
    output sfp                       expected,
    output logic                     target,
    output logic                     last_hold,
    output logic                     wrap
);

    localparam int HW = (SETTLE_CYCLES > 1) ?
                        $clog2(SETTLE_CYCLES) : 1;

    logic [N_INPUTS-1:0] pattern_q, pattern_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [N_INPUTS-1:0] sw_q, sw_d;

    // Hold counter and pattern index advance; reload on each change.
    always_comb begin
        pattern_d = pattern_q;
        hold_d    = hold_q;
        sw_d      = sw_in;
        last_hold = active &&
                    (hold_q == HW'(SETTLE_CYCLES - 1));
        wrap      = last_hold && (&pattern_q);
        if (load || !active) begin
            pattern_d = '0;
            hold_d    = '0;
        end else if (last_hold) begin
            pattern_d = pattern_q + 1'b1;
            hold_d    = '0;
        end else begin
            hold_d    = hold_q + 1'b1;
        end
    end

    // Pattern/hold/switch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            hold_q    <= '0;
            sw_q      <= '0;
        end else begin
            pattern_q <= pattern_d;
            hold_q    <= hold_d;
            sw_q      <= sw_d;
        end
    end

    // Perceptron inputs: pattern while sweeping, switches in RUN.
    always_comb begin
        target   = tbl[pattern_q];
        expected = active ? sfp_from_bit(target) : '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (active) begin
                values[i] = sfp_from_bit(pattern_q[i]);
            end else if (run) begin
                values[i] = sfp_from_bit(sw_q[i]);
            end else begin
                values[i] = '0;
            end
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Training sequencer for a single perceptron: train/eval epochs,
// early stop on full accuracy, then live inference from switches.
module perceptron_trainer
    import perceptron_trainer_pkg::*;
#(
    parameter int N_INPUTS      = 2,
    parameter int MAX_EPOCHS    = 10,
    parameter int SETTLE_CYCLES = 1,
    parameter int EPOCH_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2**N_INPUTS-1:0] truth_table,
    input  logic [N_INPUTS-1:0]    sw_in,
    perceptron_trainer_if.master   pif,
    output logic                   busy,
    output logic                   done,
    output logic                   converged,
    output logic [EPOCH_W-1:0]     epoch_count,
    output logic [N_INPUTS:0]      correct_count,
    output logic                   out_bit
);

    localparam int P = 2**N_INPUTS;
    localparam int CW = N_INPUTS + 1;

    trainer_state_e state_q, state_d;

    logic [P-1:0]       table_q, table_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [CW-1:0]      correct_q, correct_d;
    logic [CW-1:0]      hits_q, hits_d;
    logic               conv_q, conv_d;
    logic               done_q, done_d;
    logic               out_q, out_d;

    logic          load;
    logic          active;
    logic          run;
    logic          target;
    logic          last_hold;
    logic          wrap;
    logic          hit;
    logic [CW-1:0] eval_total;

    assign active = (state_q == TRAIN) || (state_q == EVAL);
    assign run    = (state_q == RUN);

    pattern_driver #(
        .N_INPUTS      (N_INPUTS),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_driver (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .active    (active),
        .run       (run),
        .tbl       (table_q),
        .sw_in     (sw_in),
        .values    (pif.values),
        .expected  (pif.expected),
        .target    (target),
        .last_hold (last_hold),
        .wrap      (wrap)
    );

    // Next-state logic and epoch/accuracy bookkeeping.
    always_comb begin
        state_d    = state_q;
        table_d    = table_q;
        epoch_d    = epoch_q;
        correct_d  = correct_q;
        hits_d     = hits_q;
        conv_d     = conv_q;
        done_d     = 1'b0;
        load       = 1'b0;
        hit        = ((pif.prediction > HALF) == target);
        eval_total = hits_q + {{N_INPUTS{1'b0}}, hit};
        unique case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    table_d   = truth_table;
                    epoch_d   = '0;
                    correct_d = '0;
                    hits_d    = '0;
                    conv_d    = 1'b0;
                    load      = 1'b1;
                    state_d   = TRAIN;
                end
            end
            TRAIN: begin
                if (wrap) begin
                    if (epoch_q != EPOCH_W'(MAX_EPOCHS)) begin
                        epoch_d = epoch_q + 1'b1;
                    end
                    hits_d  = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (last_hold) begin
                    hits_d = eval_total;
                end
                if (wrap) begin
                    correct_d = eval_total;
                    conv_d    = (eval_total == CW'(P));
                    if ((eval_total == CW'(P)) ||
                        (epoch_q == EPOCH_W'(MAX_EPOCHS))) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = TRAIN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Inference output only tracks the perceptron while in RUN.
    always_comb begin
        out_d = run && (pif.prediction > HALF);
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            table_q   <= '0;
            epoch_q   <= '0;
            correct_q <= '0;
            hits_q    <= '0;
            conv_q    <= 1'b0;
            done_q    <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            table_q   <= table_d;
            epoch_q   <= epoch_d;
            correct_q <= correct_d;
            hits_q    <= hits_d;
            conv_q    <= conv_d;
            done_q    <= done_d;
            out_q     <= out_d;
        end
    end

    assign pif.training  = (state_q == TRAIN);
    assign busy          = active;
    assign done          = done_q;
    assign converged     = conv_q;
    assign epoch_count   = epoch_q;
    assign correct_count = correct_q;
    assign out_bit       = out_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer with stub perceptrons.
// Two instances: N=2/SETTLE=1 and N=3/SETTLE=3.
module tb_perceptron_trainer;
    import perceptron_trainer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, start2;
    logic [3:0] tt1;
    logic [7:0] tt2;
    logic [1:0] sw1;
    logic [2:0] sw2;

    logic       busy1, done1, conv1, out1;
    logic [7:0] epoch1;
    logic [2:0] corr1;
    logic       busy2, done2, conv2, out2;
    logic [7:0] epoch2;
    logic [3:0] corr2;

    perceptron_trainer_if #(.N_INPUTS(2)) pif1 ();
    perceptron_trainer_if #(.N_INPUTS(3)) pif2 ();

    perceptron_trainer #(
        .N_INPUTS(2), .MAX_EPOCHS(10),
        .SETTLE_CYCLES(1), .EPOCH_W(8)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .truth_table(tt1), .sw_in(sw1), .pif(pif1),
        .busy(busy1), .done(done1), .converged(conv1),
        .epoch_count(epoch1), .correct_count(corr1),
        .out_bit(out1)
    );

    perceptron_trainer #(
        .N_INPUTS(3), .MAX_EPOCHS(10),
        .SETTLE_CYCLES(3), .EPOCH_W(8)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .truth_table(tt2), .sw_in(sw2), .pif(pif2),
        .busy(busy2), .done(done2), .converged(conv2),
        .epoch_count(epoch2), .correct_count(corr2),
        .out_bit(out2)
    );

    // Stub perceptron 1: 0 = stuck at zero, 1 = ideal AND
    // once epoch >= 3, 2 = fixed value.
    int pred_mode;
    sfp pred_fix;
    sfp pred1;
    always_comb begin
        pred1 = '0;
        case (pred_mode)
            1: if (epoch1 >= 8'd3 &&
                   pif1.values[0] == ONE &&
                   pif1.values[1] == ONE) pred1 = ONE;
            2: pred1 = pred_fix;
            default: pred1 = '0;
        endcase
    end
    assign pif1.prediction = pred1;
    assign pif2.prediction = '0;

    typedef struct {
        int epoch;
        int conv;
        int correct;
    } done_t;

    typedef struct {
        sfp [2:0] v;
        sfp       e;
    } pat_t;

    done_t dq1[$];
    done_t dq2[$];
    pat_t  pq2[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name,
                       input longint act,
                       input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d",
                     name, act, exp);
        end
    endtask

    // Monitor for instance 1 completion records.
    always @(negedge clk) begin
        if (rst_n && done1) begin
            if (dq1.size() == 0) begin
                chk("done1_unexpected", 1, 0);
            end else begin
                done_t d;
                d = dq1.pop_front();
                chk("done1_epoch", epoch1, d.epoch);
                chk("done1_conv", conv1, d.conv);
                chk("done1_correct", corr1, d.correct);
                chk("done1_busy", busy1, 0);
            end
        end
    end

    // Monitor for instance 2: per-cycle pattern and completion.
    always @(negedge clk) begin
        if (rst_n && busy2 && pq2.size() > 0) begin
            pat_t p;
            p = pq2.pop_front();
            chk("pat2_values", pif2.values, p.v);
            chk("pat2_expected", pif2.expected, p.e);
        end
        if (rst_n && done2) begin
            if (dq2.size() == 0) begin
                chk("done2_unexpected", 1, 0);
            end else begin
                done_t d;
                d = dq2.pop_front();
                chk("done2_epoch", epoch2, d.epoch);
                chk("done2_conv", conv2, d.conv);
                chk("done2_correct", corr2, d.correct);
            end
        end
    end

    task automatic pulse1();
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic pulse2();
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int which,
                             input int budget,
                             output int cycles);
        logic seen;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < budget) begin
            @(negedge clk);
            cycles++;
            seen = (which == 1) ? done1 : done2;
        end
        if (!seen) chk("done_timeout", cycles, -1);
    endtask

    initial begin
        int       c;
        int       k;
        sfp [1:0] ev;
        rst_n     = 1'b0;
        start1    = 1'b0;
        start2    = 1'b0;
        tt1       = '0;
        tt2       = '0;
        sw1       = '0;
        sw2       = '0;
        pred_mode = 0;
        pred_fix  = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_training", pif1.training, 0);
        chk("rst_done", done1, 0);
        chk("rst_conv", conv1, 0);
        chk("rst_epoch", epoch1, 0);
        chk("rst_correct", corr1, 0);
        chk("rst_out", out1, 0);
        chk("rst_values", pif1.values, 0);
        chk("rst_expected", pif1.expected, 0);
        rst_n = 1'b1;

        // N=3, SETTLE=3, XNOR-3 parity: first train+eval sweep.
        for (int pass = 0; pass < 2; pass++) begin
            for (int idx = 0; idx < 24; idx++) begin
                pat_t p;
                int   pt;
                pt = idx / 3;
                for (int i = 0; i < 3; i++)
                    p.v[i] = ((pt >> i) & 1) ? ONE : 16'sh0;
                p.e = ($countones(pt) % 2 == 0) ?
                      ONE : 16'sh0;
                pq2.push_back(p);
            end
        end
        dq2.push_back('{epoch: 10, conv: 0, correct: 4});
        tt2 = 8'b0110_1001;
        pulse2();
        wait_done(2, 600, c);

        // AND table; stub learns after epoch 3.
        pred_mode = 1;
        tt1 = 4'b1000;
        dq1.push_back('{epoch: 3, conv: 1, correct: 4});
        pulse1();
        wait_done(1, 200, c);

        // RUN: switches and thresholded output.
        sw1       = 2'b10;
        pred_mode = 2;
        pred_fix  = HALF + 16'sd1;
        @(negedge clk);
        ev[1] = ONE;
        ev[0] = '0;
        chk("run_values_10", pif1.values, ev);
        chk("run_out_above", out1, 1);
        chk("run_training", pif1.training, 0);
        pred_fix = HALF;
        sw1      = 2'b01;
        @(negedge clk);
        ev[1] = '0;
        ev[0] = ONE;
        chk("run_values_01", pif1.values, ev);
        chk("run_out_half", out1, 0);

        // AND table, stuck-zero stub: runs all epochs.
        pred_mode = 0;
        tt1 = 4'b1000;
        dq1.push_back('{epoch: 10, conv: 0, correct: 3});
        pulse1();
        chk("restart_training", pif1.training, 1);
        chk("restart_epoch", epoch1, 0);
        chk("restart_conv", conv1, 0);
        wait_done(1, 200, c);
        chk("latency", c + 1, 1 + 10 * 2 * 4 * 1);

        // Restart with OR table from RUN.
        tt1 = 4'b1110;
        pulse1();
        chk("or_training", pif1.training, 1);
        chk("or_epoch", epoch1, 0);
        chk("or_exp_p0", pif1.expected, 0);
        @(negedge clk);
        chk("or_exp_p1", pif1.expected, ONE);

        k = 0;
        while (!(busy1 && !pif1.training) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("reach_eval", busy1 && !pif1.training, 1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("busy_start_training", pif1.training, 0);
        chk("busy_start_busy", busy1, 1);
        chk("busy_start_epoch", epoch1, 1);

        // Asynchronous reset mid-EVAL.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy1, 0);
        chk("arst_training", pif1.training, 0);
        chk("arst_epoch", epoch1, 0);
        chk("arst_values", pif1.values, 0);
        chk("arst_expected", pif1.expected, 0);
        chk("arst_done", done1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy1, 0);

        chk("dq1_drained", dq1.size(), 0);
        chk("dq2_drained", dq2.size(), 0);
        chk("pq2_drained", pq2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
